uart_rx: RTL and testbench

- UART receiver for the FPGA test harness. Takes the asynchronous serial line from the host and returns 8-bit bytes to the core-side logic.
- Bit timing comes from a runtime divisor, in the same threshold style as the team's tick counters. It is the receive-side partner of the test UART transmitter path.
- Output: a one-cycle valid pulse per byte, plus error flags.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_rx_bit_timer.sv | 20 ++
 rtl/uart_rx.sv | 117 +++++++++++
 tb/tb_uart_rx.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;
  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    PARITY    = 3'd4,
    WAIT_HIGH = 3'd5
  } rx_state_t;
endpackage

// File: rtl/uart_rx_bit_timer.sv
// Bit-period tick counter: hit fires when counter+1 reaches target, then self-clears.
module rx_bit_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] target,
  output logic             hit
);
  logic [WIDTH-1:0] cnt;

  assign hit = (cnt + WIDTH'(1)) == target;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            cnt <= '0;
    else if (clear || hit) cnt <= '0;
    else                   cnt <= cnt + WIDTH'(1);
  end
endmodule

// File: rtl/uart_rx.sv
// 8-bit UART receiver with runtime bit divisor, mid-bit sampling and frame error flag.
// Optional even-parity check enabled by defining UART_RX_PARITY_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic [WIDTH-1:0]     bit_period,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);
  logic [SYNC_STAGES-1:0] sync;
  logic                   rx_s;
  rx_state_t              state;
  logic [WIDTH-1:0]       p_l, h, target;
  logic                   clear, hit;
  logic [2:0]             bit_idx;
  logic [DATA_BITS-1:0]   sh;
`ifdef UART_RX_PARITY_EN
  logic                   par;
`endif

  // Synchronizer resets to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync <= '1;
    else        sync <= {sync[SYNC_STAGES-2:0], rx};
  end
  assign rx_s = sync[SYNC_STAGES-1];

  assign busy   = (state != IDLE);
  assign clear  = (state == IDLE) || (state == WAIT_HIGH);
  assign target = (state == START) ? h : p_l;

  rx_bit_timer #(.WIDTH(WIDTH)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .target (target),
    .hit    (hit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      p_l       <= '0;
      h         <= '0;
      bit_idx   <= '0;
      sh        <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par        <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        IDLE: if (!rx_s) begin
          p_l   <= bit_period;
          h     <= bit_period >> 1;
          state <= START;
        end
        START: if (hit) begin
          bit_idx <= '0;
          state   <= rx_s ? IDLE : DATA;
        end
        DATA: if (hit) begin
          sh      <= {rx_s, sh[DATA_BITS-1:1]};
          bit_idx <= bit_idx + 3'd1;
          if (bit_idx == 3'(DATA_BITS-1))
`ifdef UART_RX_PARITY_EN
            state <= PARITY;
`else
            state <= STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (hit) begin
          par   <= rx_s;
          state <= STOP;
        end
`endif
        // Back to IDLE at mid-stop so an immediately following start bit is caught.
        STOP: if (hit) begin
          if (rx_s) begin
            data  <= sh;
            valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
            parity_err <= ^{sh, par};
`endif
            state <= IDLE;
          end else begin
            frame_err <= 1'b1;
            state     <= WAIT_HIGH;
          end
        end
        WAIT_HIGH: if (rx_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: expected bytes/flags/cycles queued at send, checked on output.
module tb_uart_rx;
  localparam int SS = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx;
  logic [15:0] bit_period;
  logic [7:0]  data;
  logic        valid, frame_err, busy;
`ifdef UART_RX_PARITY_EN
  logic        parity_err;
`endif

  uart_rx #(.WIDTH(16), .SYNC_STAGES(SS)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .bit_period (bit_period),
    .data       (data),
    .valid      (valid),
    .frame_err  (frame_err),
    .busy       (busy)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    logic       ferr;
    logic       perr;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] last_good = 8'h00;
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Output monitor: every valid/frame_err pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset && (valid || frame_err)) begin
      chk("excl", 32'(valid & frame_err), 32'd0);
      if (sb.size() == 0) begin
        chk("unexp_out", {30'd0, valid, frame_err}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("kind_ferr", 32'(frame_err), 32'(e.ferr));
        chk("lat_cyc", cyc, e.cyc);
        chk("data", 32'(data), 32'(e.d));
`ifdef UART_RX_PARITY_EN
        chk("perr", 32'(parity_err), 32'(e.perr));
`endif
      end
    end
  end

  // Caller must be at a negedge; rx falls immediately.
  task automatic send(input logic [7:0] b, input int p, input logic stop_v, input logic par_flip);
    exp_t e;
    int   extra;
    extra = 0;
`ifdef UART_RX_PARITY_EN
    extra = p;
`endif
    bit_period = 16'(p);
    e.cyc  = cyc + 1 + SS + (p >> 1) + 9 * p + extra;
    e.ferr = !stop_v;
    e.perr = stop_v & par_flip;
    e.d    = stop_v ? b : last_good;
    if (stop_v) last_good = b;
    sb.push_back(e);
    rx = 1'b0;
    repeat (p) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      rx = b[k];
      repeat (p) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^b) ^ par_flip;
    repeat (p) @(negedge clk);
`endif
    rx = stop_v;
    repeat (p) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int n;
    reset = 1'b0;
    rx = 1'b1;
    bit_period = 16'd16;
    repeat (3) @(negedge clk);
    chk("rst_data", 32'(data), 32'h00);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    idle(4);

    // 0xA5 at P=16 with busy window checks alongside
    n = cyc;
    fork
      send(8'hA5, 16, 1'b1, 1'b0);
      begin
        repeat (2) @(negedge clk);
        chk("busy_pre_d", 32'(busy), 32'd0);
        @(negedge clk);
        chk("busy_at_d", 32'(busy), 32'd1);
        repeat (n + 1 + SS + 8 + 144 - cyc - 1) @(negedge clk);
        chk("busy_pre_valid", 32'(busy), 32'd1);
        @(negedge clk);
        chk("valid_cyc", 32'(valid), 32'd1);
        chk("busy_valid_cyc", 32'(busy), 32'd0);
      end
    join
    idle(20);

    // Glitch: 5-cycle low pulse, rejected at mid-start
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    chk("glitch_busy_d7", 32'(busy), 32'd1);
    @(negedge clk);
    chk("glitch_busy_d8", 32'(busy), 32'd0);
    idle(20);

    // Frame error then break, then normal byte
    send(8'h3C, 16, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    chk("break_busy", 32'(busy), 32'd1);
    chk("break_data", 32'(data), 32'hA5);
    idle(20);
    send(8'h55, 16, 1'b1, 1'b0);
    idle(20);

    // Back-to-back at P=10
    send(8'h00, 10, 1'b1, 1'b0);
    send(8'hFF, 10, 1'b1, 1'b0);
    send(8'h81, 10, 1'b1, 1'b0);
    idle(30);

    // Reset during data bit 4 at P=8
    bit_period = 16'd8;
    rx = 1'b0;
    repeat (8) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      rx = k[0];
      repeat (8) @(negedge clk);
    end
    chk("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    rx = 1'b1;
    #1;
    chk("midrst_valid", 32'(valid), 32'd0);
    chk("midrst_data", 32'(data), 32'h00);
    chk("midrst_busy", 32'(busy), 32'd0);
    last_good = 8'h00;
    @(negedge clk);
    reset = 1'b1;
    idle(10);
    send(8'h12, 8, 1'b1, 1'b0);
    idle(10);
    chk("post_rst_data", 32'(data), 32'h12);

`ifdef UART_RX_PARITY_EN
    send(8'h07, 16, 1'b1, 1'b1);
    idle(20);
    send(8'h07, 16, 1'b1, 1'b0);
    idle(20);
`endif

    for (int i = 0; i < 2000 && sb.size() != 0; i++) @(negedge clk);
    chk("sb_drain", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
